// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) single-port memory arbiter with a starvation guard.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rd,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wd,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [1:0]    owner
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_CPU = 2'b01,
        OWN_DMA = 2'b10
    } state_t;

    state_t     state;
    state_t     tie_pick;
    logic [3:0] cpu_wait;
    logic [3:0] dma_wait;

    // Saturating wait counter: counts cycles a request sits ungranted.
    function automatic logic [3:0] wait_next(input logic req, input logic gnt,
                                             input logic [3:0] w);
        if (!req || gnt)
            return 4'd0;
        if (w >= WAIT_LIM)
            return WAIT_LIM;
        return w + 4'd1;
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dma;
    assign tie_pick = last_dma ? OWN_CPU : OWN_DMA;
`else
    assign tie_pick = OWN_CPU;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cpu_wait <= 4'd0;
            dma_wait <= 4'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dma <= 1'b1;
`endif
        end else begin
            cpu_wait <= wait_next(cpu_req, state == OWN_CPU, cpu_wait);
            dma_wait <= wait_next(dma_req, state == OWN_DMA, dma_wait);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (state == OWN_CPU)
                last_dma <= 1'b0;
            else if (state == OWN_DMA)
                last_dma <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (cpu_req && dma_req)
                        state <= tie_pick;
                    else if (cpu_req)
                        state <= OWN_CPU;
                    else if (dma_req)
                        state <= OWN_DMA;
                end
                OWN_CPU: begin
                    if (dma_req && dma_wait == WAIT_LIM)
                        state <= OWN_DMA;
                    else if (cpu_req)
                        state <= OWN_CPU;
                    else if (dma_req)
                        state <= OWN_DMA;
                    else
                        state <= IDLE;
                end
                OWN_DMA: begin
                    // A locked DMA keeps the bus until the CPU has starved long enough.
                    if (dma_req && (dma_lock || !cpu_req) && cpu_wait < WAIT_LIM)
                        state <= OWN_DMA;
                    else if (cpu_req)
                        state <= OWN_CPU;
                    else if (dma_req)
                        state <= OWN_DMA;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner   = state;
    assign cpu_gnt = (state == OWN_CPU);
    assign dma_gnt = (state == OWN_DMA);

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        case (state)
            OWN_CPU: begin
                mem_we = cpu_we & cpu_req;
                mem_a  = cpu_adr;
                mem_wd = cpu_wd;
            end
            OWN_DMA: begin
                mem_we = dma_we & dma_req;
                mem_a  = dma_adr;
                mem_wd = dma_wd;
            end
            default: ;
        endcase
    end

    assign cpu_rvalid = cpu_gnt & cpu_req & ~cpu_we;
    assign dma_rvalid = dma_gnt & dma_req & ~dma_we;
    assign cpu_rd     = cpu_gnt ? mem_rd : '0;
    assign dma_rd     = dma_gnt ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic against a
// cycle-level reference model of the arbitration rules and memory contents.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_wd, dma_rd;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [1:0]    owner;

    logic          mem_clr;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] mm  [0:255];

    int n_assert = 0;
    int n_fail   = 0;
    int m_own, m_cw, m_dw, m_last;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rd(dma_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory device: combinational read, synchronous write.
    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: who owns the bus next, from the arbitration rules.
    function automatic int model_next(input int own, input int cw, input int dw,
                                      input int last, input logic cr, input logic dr,
                                      input logic dl);
        int tie;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie = (last == 1) ? 2 : 1;
`else
        tie = 1;
`endif
        if (own == 0) begin
            if (cr && dr) return tie;
            if (cr) return 1;
            if (dr) return 2;
            return 0;
        end
        if (own == 1) begin
            if (dr && dw == MAX_WAIT) return 2;
            if (cr) return 1;
            if (dr) return 2;
            return 0;
        end
        if (dr && (dl || !cr) && cw < MAX_WAIT) return 2;
        if (cr) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            m_own = 0; m_cw = 0; m_dw = 0; m_last = 2;
        end
    endtask

    task automatic drive_cpu(input logic r, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_adr = a; cpu_wd = d;
    endtask

    task automatic drive_dma(input logic r, input logic w, input logic l,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = r; dma_we = w; dma_lock = l; dma_adr = a; dma_wd = d;
    endtask

    // Check outputs mid-cycle, then advance model and DUT by one clock.
    task automatic tick();
        logic          e_we, e_cg, e_dg;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd, e_rd;
        int            nown, ncw, ndw;
        #1;
        e_cg = (m_own == 1);
        e_dg = (m_own == 2);
        e_we = 1'b0; e_a = '0; e_wd = '0;
        if (e_cg) begin
            e_we = cpu_we & cpu_req; e_a = cpu_adr; e_wd = cpu_wd;
        end else if (e_dg) begin
            e_we = dma_we & dma_req; e_a = dma_adr; e_wd = dma_wd;
        end
        e_rd = mm[e_a[7:0]];
        chk("owner", owner, 64'(m_own));
        chk("cpu_gnt", cpu_gnt, e_cg);
        chk("dma_gnt", dma_gnt, e_dg);
        chk("mem_we", mem_we, e_we);
        chk("mem_a", mem_a, e_a);
        chk("mem_wd", mem_wd, e_wd);
        chk("cpu_rvalid", cpu_rvalid, e_cg & cpu_req & ~cpu_we);
        chk("dma_rvalid", dma_rvalid, e_dg & dma_req & ~dma_we);
        chk("cpu_rd", cpu_rd, e_cg ? e_rd : '0);
        chk("dma_rd", dma_rd, e_dg ? e_rd : '0);
        @(posedge clk);
        if (reset) begin
            if (e_we) mm[e_a[7:0]] = e_wd;
            ncw = (!cpu_req || m_own == 1) ? 0 : ((m_cw < MAX_WAIT) ? m_cw + 1 : MAX_WAIT);
            ndw = (!dma_req || m_own == 2) ? 0 : ((m_dw < MAX_WAIT) ? m_dw + 1 : MAX_WAIT);
            nown = model_next(m_own, m_cw, m_dw, m_last, cpu_req, dma_req, dma_lock);
            if (m_own != 0) m_last = m_own;
            m_own = nown; m_cw = ncw; m_dw = ndw;
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_dma(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int k;
        int exp_first, exp_second;
        for (int i = 0; i < 256; i++) mm[i] = '0;
        mem_clr = 1'b1;
        set_reset(1'b0);
        // Requests active during reset must not grant or reach memory.
        drive_cpu(1'b1, 1'b1, 32'h10, 32'h1111_2222);
        drive_dma(1'b1, 1'b1, 1'b1, 32'h20, 32'h3333_4444);
        @(negedge clk);
        tick();
        mem_clr = 1'b0;
        tick();
        idle_all();
        set_reset(1'b1);
        tick();

        // CPU write of DEADBEEF to 0x40 straight out of reset.
        drive_cpu(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        tick();
        chk("r030_gnt", cpu_gnt, 1'b1);
        chk("r030_we", mem_we, 1'b1);
        tick();
        chk("r030_mem", mem[8'h40], 32'hDEAD_BEEF);
        // Request dropped while still granted: no write, no rvalid.
        drive_cpu(1'b0, 1'b1, 32'h40, 32'h0BAD_0BAD);
        #1;
        chk("r024_we", mem_we, 1'b0);
        chk("r024_gnt", cpu_gnt, 1'b1);
        tick();
        chk("r024_mem", mem[8'h40], 32'hDEAD_BEEF);
        chk("r024_idle", owner, 2'b00);

        // DMA read back of 0x40.
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_dma(1'b1, 1'b0, 1'b0, 32'h40, '0);
        tick();
        chk("r034_rvalid", dma_rvalid, 1'b1);
        chk("r034_rd", dma_rd, 32'hDEAD_BEEF);
        chk("r034_cpu_rd", cpu_rd, 32'h0);
        idle_all();
        tick();

        // CPU streaming; DMA must get in after the starvation limit.
        drive_cpu(1'b1, 1'b1, 32'h50, 32'hC0DE_0001);
        tick();
        chk("r031_cpu_first", cpu_gnt, 1'b1);
        drive_dma(1'b1, 1'b1, 1'b0, 32'h60, 32'hD0A0_0001);
        k = 0;
        while (!dma_gnt && k < 20) begin
            tick();
            k++;
        end
        chk("r031_latency", 64'(k), 64'(MAX_WAIT + 1));
        tick();
        chk("r031_cpu_back", cpu_gnt, 1'b1);
        chk("r031_dma_mem", mem[8'h60], 32'hD0A0_0001);
        idle_all();
        tick();
        tick();

        // Locked DMA burst; CPU raised at cycle 2 must be served by cycle 7.
        drive_dma(1'b1, 1'b0, 1'b1, 32'h40, '0);
        tick();
        tick();
        drive_cpu(1'b1, 1'b0, 32'h40, '0);
        k = 0;
        while (!cpu_gnt && k < 20) begin
            tick();
            k++;
        end
        chk("r032_latency_ok", 64'(k <= MAX_WAIT + 1), 64'd1);
        chk("r032_cpu_rd", cpu_rd, 32'hDEAD_BEEF);
        idle_all();
        tick();
        tick();

        // Simultaneous requests from IDLE, three rounds.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_first = 1; exp_second = 2;
`else
        exp_first = 1; exp_second = 1;
`endif
        for (int r = 0; r < 3; r++) begin
            drive_cpu(1'b1, 1'b0, 32'h40, '0);
            drive_dma(1'b1, 1'b0, 1'b0, 32'h40, '0);
            tick();
            chk("r033_owner", owner, 64'((r == 1) ? exp_second : exp_first));
            idle_all();
            tick();
            tick();
        end

        // Reset during a granted write aborts it.
        drive_cpu(1'b1, 1'b1, 32'h80, 32'hAAAA_5555);
        tick();
        chk("r035_pre_we", mem_we, 1'b1);
        set_reset(1'b0);
        #1;
        chk("r035_we", mem_we, 1'b0);
        chk("r035_owner", owner, 2'b00);
        chk("r035_gnt", cpu_gnt, 1'b0);
        tick();
        chk("r035_mem", mem[8'h80], 32'h0);
        set_reset(1'b1);
        tick();
        chk("r027_gnt", cpu_gnt, 1'b1);
        idle_all();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                      AW'($urandom_range(0, 255)), $urandom);
            drive_dma($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) < 3, AW'($urandom_range(0, 255)), $urandom);
            tick();
        end
        idle_all();
        tick();
        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], mm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, starvation limit in cycles, range 1..15.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req / cpu_we  input  1 each  CPU access request / write enable.
REQ-007 SHALL have ports cpu_adr / cpu_wd  input  AW / DW  CPU address / write data.
REQ-008 SHALL have ports cpu_gnt / cpu_rvalid  output  1 each  CPU owns memory this cycle / read data valid.
REQ-009 SHALL have port cpu_rd  output  DW  CPU read data.
REQ-010 SHALL have ports dma_req / dma_we / dma_lock  input  1 each  DMA request / write enable / hold ownership.
REQ-011 SHALL have ports dma_adr / dma_wd  input  AW / DW  DMA address / write data.
REQ-012 SHALL have ports dma_gnt / dma_rvalid  output  1 each; dma_rd  output  DW.
REQ-013 SHALL have ports mem_we  output  1; mem_a  output  AW; mem_wd  output  DW; mem_rd  input  DW (combinational-read, synchronous-write memory).
REQ-014 SHALL have port owner  output  2  00 idle, 01 CPU, 10 DMA.

Function
REQ-015 SHALL use registered FSM states IDLE, OWN_CPU, OWN_DMA; owner and x_gnt decode state directly.
REQ-016 SHALL perform one memory access per granted cycle; mem_a/mem_wd muxed from owner; mem_we = owner_we & owner_req.
REQ-017 SHALL drive mem_we, mem_a, mem_wd to 0 in IDLE.
REQ-018 SHALL drive x_rd = mem_rd and x_rvalid = x_gnt & x_req & ~x_we in the same cycle; non-owner rd = 0.
REQ-019 SHALL grant one cycle after request is sampled (request at edge N -> gnt during cycle N+1).
REQ-020 From IDLE: cpu_req -> OWN_CPU; else dma_req -> OWN_DMA; else stay.
REQ-021 From OWN_CPU: dma_wait == MAX_WAIT and dma_req -> OWN_DMA; else cpu_req -> stay; else dma_req -> OWN_DMA; else IDLE.
REQ-022 From OWN_DMA: dma_req & (dma_lock | ~cpu_req) & cpu_wait < MAX_WAIT -> stay; else cpu_req -> OWN_CPU; else dma_req -> stay; else IDLE.
REQ-023 SHALL keep 4-bit cpu_wait/dma_wait counters: increment while req & ~gnt, saturate at MAX_WAIT, clear when gnt or req low.
REQ-024 Request dropped while granted SHALL produce no write and rvalid = 0 that cycle; FSM re-arbitrates at next edge.
REQ-025 Requester inputs SHALL be held stable by requester until gnt; arbiter SHALL NOT latch them.

Reset
REQ-026 SHALL on reset low immediately force IDLE, owner = 00, all gnt/rvalid/mem_we = 0, rd/mem_a/mem_wd = 0, both wait counters = 0.
REQ-027 Reset asserted mid-access SHALL abort it with no write; first grant follows first edge after release.

Configuration
REQ-028 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous cpu_req and dma_req in IDLE SHALL grant the requester not granted most recently (last-owner register, reset to DMA so CPU wins first).
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests in IDLE SHALL grant CPU (REQ-020); starvation guard applies in both builds.

Verification
REQ-030 cpu_req=1, cpu_we=1, adr=0x40, wd=0xDEADBEEF from reset -> cpu_gnt next cycle, mem_we=1, memory[0x40]=0xDEADBEEF.
REQ-031 cpu_req held continuously, dma_req=1 -> dma_gnt within MAX_WAIT+1=5 cycles, one DMA beat, then CPU regains.
REQ-032 dma_req+dma_lock held 10 cycles, cpu_req raised at cycle 2 -> cpu_gnt no later than cycle 2+MAX_WAIT+1=7.
REQ-033 Both requests from IDLE -> CPU wins (default build); with MEM_ARB_ROUND_ROBIN_EN alternate CPU, DMA, CPU.
REQ-034 DMA read adr=0x40 after REQ-030 -> dma_rvalid=1, dma_rd=0xDEADBEEF, cpu_rd=0.
REQ-035 reset low during granted write -> mem_we drops same cycle, owner=00, memory unchanged.
